// File: rtl/alu_bist.sv
// Built-in self-test sequencer for the 32-bit ALU: LFSR operand generation,
// per-opcode result compaction into a MISR and a final golden-signature check.
module alu_bist #(
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2B5D,
    parameter logic [15:0] OP_MASK     = 16'h33BA,
    parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_q
);

    localparam int unsigned VEC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);
    localparam logic [31:0] SEED_EFF = (LFSR_SEED == '0) ? 32'h0000_0001 : LFSR_SEED;

    function automatic logic [3:0] first_op(input logic [15:0] m);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (m[i-1]) r = 4'(i - 1);
        end
        return r;
    endfunction

    localparam logic [3:0] FIRST_OP = first_op(OP_MASK);

    typedef enum logic [2:0] {
        IDLE, GEN_A, GEN_B, APPLY, SAMPLE, CHECK
    } state_t;

    state_t           r_state;
    logic [31:0]      r_lfsr;
    logic [31:0]      r_misr;
    logic [VEC_W-1:0] r_vec;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [3:0]       r_alu_control;

    logic [31:0]      w_lfsr_next;
    logic [31:0]      w_misr_next;
    logic             w_has_next;
    logic [3:0]       w_next_op;

    assign w_lfsr_next = {r_lfsr[30:0], 1'b0} ^ (r_lfsr[31] ? 32'h04C1_1DB7 : 32'h0);
    assign w_misr_next = {r_misr[30:0], 1'b0} ^ (r_misr[31] ? 32'h0040_0007 : 32'h0) ^ alu_q;

    // Scanning downward leaves the lowest enabled opcode above the current one.
    always_comb begin
        w_has_next = 1'b0;
        w_next_op  = r_alu_control;
        for (int unsigned j = 0; j < 16; j++) begin
            if (OP_MASK[15-j] && (4'(15 - j) > r_alu_control)) begin
                w_has_next = 1'b1;
                w_next_op  = 4'(15 - j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_lfsr        <= '0;
            r_misr        <= '0;
            r_vec         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_lfsr  <= SEED_EFF;
                        r_misr  <= '0;
                        r_vec   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_state <= (OP_MASK == '0) ? CHECK : GEN_A;
                    end
                end
                GEN_A: begin
                    r_alu_a <= r_lfsr;
                    r_lfsr  <= w_lfsr_next;
                    r_state <= GEN_B;
                end
                GEN_B: begin
                    r_alu_b       <= r_lfsr;
                    r_lfsr        <= w_lfsr_next;
                    r_alu_control <= FIRST_OP;
                    r_state       <= APPLY;
                end
                APPLY: begin
                    r_state <= SAMPLE;
                end
                SAMPLE: begin
                    r_misr <= w_misr_next;
                    if (w_has_next) begin
                        r_alu_control <= w_next_op;
                        r_state       <= APPLY;
                    end else if (r_vec == LAST_VEC) begin
                        r_state <= CHECK;
                    end else begin
                        r_vec   <= r_vec + 1'b1;
                        r_state <= GEN_A;
                    end
                end
                CHECK: begin
                    r_pass  <= (r_misr == GOLDEN_SIG);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign signature   = r_misr;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_control;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: several parameterisations against behavioural ALUs,
// run table with a signature/pass/length scoreboard plus reset and control corner cases.
module tb_alu_bist;

    localparam logic [31:0] DEF_SEED = 32'hACE1_2B5D;
    localparam logic [15:0] DEF_MASK = 16'h33BA;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            4'd6:    return a - b;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return ~(a | b);
            4'd9:    return a + 32'd1;
            4'd12:   return ~a;
            4'd13:   return {a[15:0], b[31:16]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? 32'h04C1_1DB7 : 32'h0);
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] x, input logic [31:0] q);
        return {x[30:0], 1'b0} ^ (x[31] ? 32'h0040_0007 : 32'h0) ^ q;
    endfunction

    // flip_idx selects the global sample number whose alu_q[0] is inverted (-1: none).
    function automatic logic [31:0] model_sig(input logic [31:0] seed, input int nvec,
                                              input logic [15:0] mask, input int flip_idx);
        logic [31:0] lf, ms, a, b, q;
        int s;
        lf = (seed == 32'h0) ? 32'h1 : seed;
        ms = 32'h0;
        s  = 0;
        for (int v = 0; v < nvec; v++) begin
            a  = lf;
            lf = lfsr_step(lf);
            b  = lf;
            lf = lfsr_step(lf);
            for (int op = 0; op < 16; op++) begin
                if (mask[op]) begin
                    q = alu_model(a, b, 4'(op));
                    if (s == flip_idx) q = q ^ 32'h1;
                    ms = misr_step(ms, q);
                    s++;
                end
            end
        end
        return ms;
    endfunction

    localparam logic [31:0] GOLD = model_sig(DEF_SEED, 16, DEF_MASK, -1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flip = 1'b0;
    logic        start_v [5];
    logic        busy_v  [5];
    logic        done_v  [5];
    logic        pass_v  [5];
    logic [31:0] sig_v   [5];
    logic [31:0] a_v     [5];
    logic [31:0] b_v     [5];
    logic [3:0]  c_v     [5];
    logic [31:0] q_v     [5];

    always #5 clk = ~clk;

    assign q_v[0] = 32'h0;
    assign q_v[1] = 32'hFFFF_FFFF;
    assign q_v[2] = alu_model(a_v[2], b_v[2], c_v[2]);
    assign q_v[3] = alu_model(a_v[3], b_v[3], c_v[3]) ^ {31'b0, flip};
    assign q_v[4] = alu_model(a_v[4], b_v[4], c_v[4]);

    alu_bist #(.NUM_VECTORS(1), .LFSR_SEED(32'h1), .OP_MASK(16'h0001), .GOLDEN_SIG(32'h0)) u_zero (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .signature(sig_v[0]), .alu_a(a_v[0]), .alu_b(b_v[0]),
        .alu_control(c_v[0]), .alu_q(q_v[0]));

    alu_bist #(.NUM_VECTORS(1), .LFSR_SEED(32'h1), .OP_MASK(16'h0001), .GOLDEN_SIG(32'h0)) u_ones (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .signature(sig_v[1]), .alu_a(a_v[1]), .alu_b(b_v[1]),
        .alu_control(c_v[1]), .alu_q(q_v[1]));

    alu_bist u_def (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .signature(sig_v[2]), .alu_a(a_v[2]), .alu_b(b_v[2]),
        .alu_control(c_v[2]), .alu_q(q_v[2]));

    alu_bist #(.GOLDEN_SIG(GOLD)) u_gold (
        .clk(clk), .rst(rst), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .pass(pass_v[3]), .signature(sig_v[3]), .alu_a(a_v[3]), .alu_b(b_v[3]),
        .alu_control(c_v[3]), .alu_q(q_v[3]));

    alu_bist #(.OP_MASK(16'h0000)) u_nomask (
        .clk(clk), .rst(rst), .start(start_v[4]), .busy(busy_v[4]), .done(done_v[4]),
        .pass(pass_v[4]), .signature(sig_v[4]), .alu_a(a_v[4]), .alu_b(b_v[4]),
        .alu_control(c_v[4]), .alu_q(q_v[4]));

    typedef struct {
        int          inst;
        bit          flip;
        bit          poke;
        logic [31:0] sig;
        logic        pass;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] sig;
        logic        pass;
        int          cyc;
    } exp_t;

    vec_t tbl [7];
    exp_t sb [$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one run, counts busy cycles (bounded) and applies optional disturbances.
    task automatic run(input vec_t r, output int cyc);
        int k;
        k = r.inst;
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        cyc = 0;
        while (busy_v[k] === 1'b1 && cyc < 2000) begin
            if (r.flip && cyc == 13) flip = 1'b1;
            if (r.flip && cyc == 14) flip = 1'b0;
            if (r.poke && cyc == 7)  start_v[k] = 1'b1;
            if (r.poke && cyc == 8)  start_v[k] = 1'b0;
            if (r.poke && cyc == r.cyc - 1) start_v[k] = 1'b1;
            cyc++;
            tick();
        end
        start_v[k] = 1'b0;
        flip = 1'b0;
    endtask

    initial begin
        int   cyc;
        exp_t e;

        for (int i = 0; i < 5; i++) start_v[i] = 1'b0;

        tbl[0] = '{inst: 0, flip: 1'b0, poke: 1'b0, sig: 32'h0,         pass: 1'b1, cyc: 5};
        tbl[1] = '{inst: 1, flip: 1'b0, poke: 1'b0, sig: 32'hFFFF_FFFF, pass: 1'b0, cyc: 5};
        tbl[2] = '{inst: 2, flip: 1'b0, poke: 1'b1, sig: GOLD, pass: (GOLD == 32'h0), cyc: 321};
        tbl[3] = '{inst: 3, flip: 1'b0, poke: 1'b0, sig: GOLD, pass: 1'b1, cyc: 321};
        tbl[4] = '{inst: 3, flip: 1'b1, poke: 1'b0,
                   sig: model_sig(DEF_SEED, 16, DEF_MASK, 5), pass: 1'b0, cyc: 321};
        tbl[5] = '{inst: 3, flip: 1'b0, poke: 1'b1, sig: GOLD, pass: 1'b1, cyc: 321};
        tbl[6] = '{inst: 4, flip: 1'b0, poke: 1'b1, sig: 32'h0,         pass: 1'b1, cyc: 1};

        tick();
        tick();
        chk("reset_zero_outs", {31'b0, busy_v[0] | done_v[0] | pass_v[0]}, 32'h0);
        chk("reset_def_sig", sig_v[2], 32'h0);
        chk("reset_def_ops", a_v[2] | b_v[2] | {28'b0, c_v[2]}, 32'h0);
        rst = 1'b0;
        tick();

        // Reset asserted mid-run with start held high.
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        repeat (20) tick();
        chk("mid_run_busy", {31'b0, busy_v[2]}, 32'h1);
        rst = 1'b1;
        start_v[2] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_flags", {29'b0, busy_v[2], done_v[2], pass_v[2]}, 32'h0);
            chk("rst_sig", sig_v[2], 32'h0);
            chk("rst_ops", a_v[2] | b_v[2] | {28'b0, c_v[2]}, 32'h0);
        end
        rst = 1'b0;
        start_v[2] = 1'b0;
        tick();
        chk("rst_start_ignored", {31'b0, busy_v[2]}, 32'h0);

        // Operands seen by the ALU during APPLY of the constant-zero configuration.
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        chk("apply_alu_a", a_v[0], 32'h1);
        chk("apply_alu_b", b_v[0], 32'h2);
        chk("apply_ctrl", {28'b0, c_v[0]}, 32'h0);
        for (int i = 0; i < 20 && busy_v[0] === 1'b1; i++) tick();
        chk("apply_run_end", {31'b0, busy_v[0]}, 32'h0);

        // Reset at cycle 50 of a run discards it.
        start_v[3] = 1'b1;
        tick();
        start_v[3] = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst50_state", {30'b0, busy_v[3], done_v[3]}, 32'h0);
        chk("rst50_sig", sig_v[3], 32'h0);
        tick();

        for (int i = 0; i < 7; i++) begin
            sb.push_back('{sig: tbl[i].sig, pass: tbl[i].pass, cyc: tbl[i].cyc});
            run(tbl[i], cyc);
            e = sb.pop_front();
            chk($sformatf("row%0d_busy_cycles", i), cyc, e.cyc);
            chk($sformatf("row%0d_done", i), {31'b0, done_v[tbl[i].inst]}, 32'h1);
            chk($sformatf("row%0d_signature", i), sig_v[tbl[i].inst], e.sig);
            chk($sformatf("row%0d_pass", i), {31'b0, pass_v[tbl[i].inst]}, {31'b0, e.pass});
            if (tbl[i].poke) begin
                tick();
                chk($sformatf("row%0d_start_at_done", i), {31'b0, busy_v[tbl[i].inst]}, 32'h0);
                chk($sformatf("row%0d_done_held", i), {31'b0, done_v[tbl[i].inst]}, 32'h1);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test sequencer for the 32-bit ALU (`alu_32`). It drives `alu_a`, `alu_b` and `alu_control` toward an external ALU instance and consumes its `q` output. Operand pairs come from a seeded LFSR, and results are compacted into a 32-bit MISR signature. After the last vector it compares the signature with a golden value and raises pass/fail. It sits beside `alu_32` in the CPU test path, and its operand/opcode bus is muxed onto the ALU inputs while `busy` is high.

## Interface
- `NUM_VECTORS`, default 16: number of operand pairs; must be ≥ 1.
- `LFSR_SEED`, default 32'hACE1_2B5D: initial LFSR state; a value of 0 is replaced by 32'h0000_0001.
- `OP_MASK`, default 16'h33BA: bit k set means opcode k is exercised.
- `GOLDEN_SIG`, default 32'h0000_0000: expected final signature.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: pulse that launches a run; sampled only in IDLE.
- `busy  out  1`: high from the start-accept edge until CHECK completes.
- `done  out  1`: high after a run finishes; held until the next accepted start or rst.
- `pass  out  1`: valid when `done`=1; high when signature == `GOLDEN_SIG`.
- `signature  out  32`: live MISR value; final value valid when `done`=1.
- `alu_a  out  32`: registered operand A to the ALU.
- `alu_b  out  32`: registered operand B to the ALU.
- `alu_control  out  4`: registered opcode to the ALU.
- `alu_q  in  32`: ALU result, treated as combinational from `alu_a`/`alu_b`/`alu_control`.

## Operation
- State set: IDLE, GEN_A, GEN_B, APPLY, SAMPLE, CHECK.
- LFSR step: `lfsr_next = {lfsr[30:0],1'b0} ^ (lfsr[31] ? 32'h04C1_1DB7 : 0)`.
- MISR step: `misr_next = {misr[30:0],1'b0} ^ (misr[31] ? 32'h0040_0007 : 0) ^ alu_q`.
- IDLE, when `start`=1:
  - load lfsr=seed, misr=0, vec=0;
  - set `busy`=1 and clear `done` and `pass`;
  - go to GEN_A, or go to CHECK if `OP_MASK`==0.
- GEN_A: `alu_a` <= lfsr; lfsr steps; go to GEN_B.
- GEN_B: `alu_b` <= lfsr; lfsr steps; `alu_control` <= lowest set bit index of `OP_MASK`; go to APPLY.
- APPLY: one settle cycle with inputs stable; go to SAMPLE.
- SAMPLE: misr updates with `alu_q`. Next state:
  - if a higher set bit exists in `OP_MASK`, `alu_control` <= the next higher set index and go to APPLY;
  - else if vec == `NUM_VECTORS`-1, go to CHECK;
  - else vec++ and go to GEN_A.
- CHECK: `pass` <= (misr == `GOLDEN_SIG`); `done` <= 1; `busy` <= 0; go to IDLE.
- Opcodes within a vector are applied in ascending order. `alu_a` and `alu_b` hold their values across all opcodes of a vector.
- Arithmetic is modulo 2^32. `vec` is sized as clog2(`NUM_VECTORS`) with a minimum of 1 bit.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `signature`=0, `alu_a`=0, `alu_b`=0, `alu_control`=0, state=IDLE.
- `rst` during a run returns the block to these values on the next edge and the run is discarded. `rst` has priority over `start`.
- With K = popcount(`OP_MASK`), a run takes `NUM_VECTORS`*(2+2K)+1 cycles of `busy`.
- `done` rises on the same edge that `busy` falls.
- `alu_q` is sampled on the edge that ends SAMPLE, which is a full cycle after `alu_control` changes.
- `start` is ignored while `busy`=1. A `start` asserted in the same cycle `done` rises is not accepted.
- With `OP_MASK`==0: `busy` lasts 1 cycle, `signature`=0, and `pass` = (`GOLDEN_SIG`==0).
- Back-to-back runs with identical parameters and ALU produce an identical `signature`.

## Test plan
- Reset: hold `rst` for 2 cycles mid-pattern. All outputs must read 0 and `start` must be ignored while `rst`=1.
- Constant-zero ALU: `NUM_VECTORS`=1, `OP_MASK`=16'h0001, `LFSR_SEED`=1, `alu_q` tied to 0.
  - `alu_a`=1 and `alu_b`=2 during APPLY;
  - `busy` high exactly 5 cycles;
  - `signature`=0 and `pass`=1.
- Stuck-at-one ALU: same parameters with `alu_q` tied to 32'hFFFF_FFFF. Final `signature` must be 32'hFFFF_FFFF and `pass`=0.
- Real `alu_32`, default parameters (opcodes 1,3,4,5,7,8,9,12,13):
  - `busy` must last 16*20+1 = 321 cycles;
  - `signature` must match the bench software model and `pass`=1 when `GOLDEN_SIG` is set to it;
  - flipping `alu_q[0]` on a single sample must give `pass`=0.
- Control boundaries:
  - `start` pulsed while `busy`=1 must have no effect;
  - `rst` at cycle 50 of a run must return the block to idle, and a restart must reproduce the same final signature;
  - `OP_MASK`=0 must give a 1-cycle run with `signature`=0.
